// File: rtl/gcd_job_scheduler.sv
// Round-robin scheduler sharing one iterative GCD engine between NREQ requesters.
// Define GCD_SCHED_TIMEOUT_EN to abort jobs whose engine stays silent for TIMEOUT cycles.
module gcd_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_res,
  output logic              rsp_err,
  output logic              eng_load,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_res
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr, owner, grant_idx;
  logic             grant_found, transfer, zero_op;
  logic [W-1:0]     grant_a, grant_b;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
`endif

  // Search starts at rr_ptr and wraps, so the last requester served has lowest priority.
  always_comb begin : grant_sel
    logic [PTR_W:0] slot;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = '0;
    for (int i = 0; i < NREQ; i++) begin
      slot = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (slot >= (PTR_W + 1)'(NREQ)) slot = slot - (PTR_W + 1)'(NREQ);
      if (!grant_found && req_valid[slot[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = slot[PTR_W-1:0];
      end
    end
  end

  always_comb begin : operand_mux
    grant_a = '0;
    grant_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == PTR_W'(j)) begin
        grant_a = req_a[j*W +: W];
        grant_b = req_b[j*W +: W];
      end
    end
  end

  assign transfer = (state == IDLE) && grant_found && !reset;
  assign zero_op  = (grant_a == '0) || (grant_b == '0);

  always_comb begin : fsm_next
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    eng_load   = 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: if (transfer) begin
        req_ready  = NREQ'(1) << grant_idx;
        state_next = zero_op ? RESP : ISSUE;
      end
      ISSUE: begin
        eng_load   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (eng_done) state_next = RESP;
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid = NREQ'(1) << owner;
        if (rsp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only control and output registers need reset; a reset mid-job simply drops the job.
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      eng_a   <= '0;
      eng_b   <= '0;
      rsp_res <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
      rsp_err <= 1'b0;
      to_cnt  <= '0;
`endif
    end else begin
      state <= state_next;
      if (transfer) begin
        owner  <= grant_idx;
        eng_a  <= grant_a;
        eng_b  <= grant_b;
        rr_ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        if (zero_op) rsp_res <= (grant_a == '0) ? grant_b : grant_a;
`ifdef GCD_SCHED_TIMEOUT_EN
        rsp_err <= 1'b0;
`endif
      end
      if (state == WAIT && eng_done) rsp_res <= eng_res;
`ifdef GCD_SCHED_TIMEOUT_EN
      if (state == ISSUE) to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + TO_W'(1);
      if (timeout_hit) begin
        rsp_res <= '0;
        rsp_err <= 1'b1;
      end
`endif
    end
  end

`ifndef GCD_SCHED_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler: directed scenarios then random jobs,
// checked against a Euclid-based GCD reference and a round-robin grant model.
module tb_gcd_job_scheduler;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [7:0]  rsp_res;
  logic        rsp_err;
  logic        eng_load;
  logic [7:0]  eng_a, eng_b;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_res = '0;

  int errors = 0;
  int checks = 0;
  int ptr_model = 0;
  int eng_lat = 5;
  bit eng_hang = 1'b0;
  logic eng_busy = 1'b0;
  int eng_cnt = 0;
  logic [7:0] eng_val = '0;

  always #5 clk = ~clk;

  gcd_job_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .eng_load(eng_load), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_res(eng_res)
  );

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  function automatic int exp_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [31:0] pack(input int idx, input logic [7:0] v);
    return 32'(v) << (8 * idx);
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] x, input int idx);
    return 8'(x >> (8 * idx));
  endfunction

  // Engine stand-in: done level drops on load, rises eng_lat cycles later, held until the next load.
  always @(posedge clk) begin
    if (eng_load) begin
      eng_done <= 1'b0;
      eng_busy <= 1'b1;
      eng_cnt  <= eng_lat - 1;
      eng_val  <= ref_gcd(eng_a, eng_b);
    end else if (eng_busy) begin
      if (eng_cnt <= 1 && !eng_hang) begin
        eng_done <= 1'b1;
        eng_res  <= eng_val;
        eng_busy <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_eng_load", eng_load, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
    @(negedge clk);
    reset = 1'b0;
    ptr_model = 0;
  endtask

  task automatic accept(input logic [3:0] v, input logic [31:0] as, input logic [31:0] bs,
                        output int gnt);
    logic [3:0] oh;
    @(negedge clk);
    req_valid = v;
    req_a = as;
    req_b = bs;
    #1;
    gnt = exp_grant(v, ptr_model);
    oh = 4'(1 << gnt);
    check("req_ready_grant", req_ready, oh);
    check("rsp_valid_idle", rsp_valid, 0);
    @(posedge clk);
    #1;
    ptr_model = (gnt + 1) % NREQ;
    req_valid = req_valid & ~oh;
  endtask

  // Entered one cycle after the accept edge (cycle T+1); exp_n counts cycles from T to rsp_valid.
  task automatic finish_job(input int gnt, input logic [7:0] a, input logic [7:0] b, input int exp_n,
                            input logic [7:0] exp_res, input logic exp_err, input int hold);
    logic [3:0] oh;
    int n;
    int extra_loads;
    oh = 4'(1 << gnt);
    n = 1;
    extra_loads = 0;
    check("eng_load_T1", eng_load, (a != 0 && b != 0));
    if (a != 0 && b != 0) begin
      check("eng_a", eng_a, a);
      check("eng_b", eng_b, b);
    end
    while (rsp_valid == '0 && n < 200) begin
      check("req_ready_busy", req_ready, 0);
      @(posedge clk);
      #1;
      n++;
      if (eng_load) extra_loads++;
    end
    check("eng_load_once", extra_loads, 0);
    check("latency", n, exp_n);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_res", rsp_res, exp_res);
    check("rsp_err", rsp_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh;
      @(posedge clk);
      #1;
      check("rsp_valid_hold", rsp_valid, oh);
      check("rsp_res_hold", rsp_res, exp_res);
      check("req_ready_hold", req_ready, 0);
    end
    rsp_ready = oh;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    check("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [3:0]  valids;
    logic [31:0] as, bs;
    logic [7:0]  a, b;

    apply_reset();

    // Single engine job with the response held back for ten cycles.
    eng_lat = 5;
    accept(4'b0001, pack(0, 8'd48), pack(0, 8'd18), g);
    finish_job(g, 8'd48, 8'd18, eng_lat + 2, ref_gcd(8'd48, 8'd18), 1'b0, 10);
    check("gcd_48_18", rsp_res, 6);

    // Several simultaneous requesters served in round-robin order, then a wrap.
    valids = 4'b1110;
    as = pack(1, 8'd12) | pack(2, 8'd100) | pack(3, 8'd81);
    bs = pack(1, 8'd8)  | pack(2, 8'd75)  | pack(3, 8'd27);
    for (int k = 0; k < 3; k++) begin
      eng_lat = 2 + k;
      accept(valids, as, bs, g);
      valids = valids & ~4'(1 << g);
      finish_job(g, lane(as, g), lane(bs, g), eng_lat + 2, ref_gcd(lane(as, g), lane(bs, g)), 1'b0, k);
    end
    valids = 4'b0101;
    as = pack(0, 8'd20) | pack(2, 8'd14);
    bs = pack(0, 8'd15) | pack(2, 8'd21);
    for (int k = 0; k < 2; k++) begin
      eng_lat = 3;
      accept(valids, as, bs, g);
      valids = valids & ~4'(1 << g);
      finish_job(g, lane(as, g), lane(bs, g), eng_lat + 2, ref_gcd(lane(as, g), lane(bs, g)), 1'b0, 1);
    end

    // Zero-operand bypass: response one cycle after accept, engine untouched.
    accept(4'b0100, pack(2, 8'd0), pack(2, 8'd35), g);
    finish_job(g, 8'd0, 8'd35, 1, 8'd35, 1'b0, 2);
    accept(4'b0100, pack(2, 8'd0), pack(2, 8'd0), g);
    finish_job(g, 8'd0, 8'd0, 1, 8'd0, 1'b0, 0);
    accept(4'b0010, pack(1, 8'd20), pack(1, 8'd0), g);
    finish_job(g, 8'd20, 8'd0, 1, 8'd20, 1'b0, 1);

    // Reset while waiting on the engine: job abandoned, pointer back to zero.
    eng_lat = 8;
    accept(4'b0010, pack(1, 8'd30), pack(1, 8'd12), g);
    repeat (3) @(posedge clk);
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check("abandoned_rsp", rsp_valid, 0);
    end
    eng_lat = 3;
    accept(4'b1010, pack(1, 8'd44) | pack(3, 8'd9), pack(1, 8'd33) | pack(3, 8'd3), g);
    finish_job(g, 8'd44, 8'd33, eng_lat + 2, ref_gcd(8'd44, 8'd33), 1'b0, 0);

    // Engine that never finishes.
    eng_hang = 1'b1;
    accept(4'b1000, pack(3, 8'd9), pack(3, 8'd6), g);
`ifdef GCD_SCHED_TIMEOUT_EN
    finish_job(g, 8'd9, 8'd6, TIMEOUT + 2, 8'd0, 1'b1, 1);
    eng_hang = 1'b0;
`else
    for (int c = 0; c < 60; c++) begin
      check("no_timeout_rsp", rsp_valid, 0);
      @(posedge clk);
      #1;
    end
    eng_hang = 1'b0;
    apply_reset();
`endif

    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      int hold;
      valids = 4'($urandom_range(1, 15));
      as = '0;
      bs = '0;
      for (int i = 0; i < NREQ; i++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) a = '0;
        if ($urandom_range(0, 9) == 0) b = '0;
        as = as | pack(i, a);
        bs = bs | pack(i, b);
      end
      eng_lat = $urandom_range(2, 8);
      hold = $urandom_range(0, 3);
      accept(valids, as, bs, g);
      a = lane(as, g);
      b = lane(bs, g);
      finish_job(g, a, b, (a == 0 || b == 0) ? 1 : eng_lat + 2, ref_gcd(a, b), 1'b0, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
